// File: rtl/qbert_pkg.sv
// Shared types and helpers for the Q*bert pyramid controllers.
package qbert_pkg;

  localparam int N_CUBE = 28;
  localparam logic [N_CUBE-1:0] TOP = 28'h1;

  typedef enum logic [2:0] {
    DIR_NONE       = 3'd0,
    DIR_DOWN_RIGHT = 3'd1,
    DIR_DOWN_LEFT  = 3'd2,
    DIR_UP_RIGHT   = 3'd3,
    DIR_UP_LEFT    = 3'd4
  } dir_e;

  typedef enum logic [2:0] {
    LQ_START  = 3'd0,
    LQ_JUMP   = 3'd1,
    LQ_IDLE   = 3'd2,
    LQ_SAUCER = 3'd3,
    LQ_KO     = 3'd4
  } layer_state_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_MOVE, S_LAND, S_KO_A, S_KO_B, S_OVER
  } ctrl_state_e;

  function automatic logic dir_legal(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'd4);
  endfunction

  // Cube n = r(r-1)/2 + k lives at bit n-1; only meaningful for on-pyramid (r,k).
  function automatic logic [N_CUBE-1:0] rk_onehot(input logic [3:0] r, input logic [3:0] k);
    logic [5:0] r6;
    logic [5:0] idx;
    r6  = {2'b00, r};
    idx = ((r6 * (r6 - 6'd1)) >> 1) + {2'b00, k} - 6'd1;
    return TOP << idx;
  endfunction

endpackage

// File: rtl/qbert_cube_nav.sv
// Combinational pyramid navigator: (row, slot, direction) -> destination cube.
module qbert_cube_nav
  import qbert_pkg::*;
(
  input  logic [2:0]        r,
  input  logic [2:0]        k,
  input  logic [2:0]        dir,
  output logic [2:0]        r_next,
  output logic [2:0]        k_next,
  output logic              off,
  output logic [N_CUBE-1:0] onehot
);

  logic [3:0] rn;
  logic [3:0] kn;

  always_comb begin
    rn = {1'b0, r};
    kn = {1'b0, k};
    case (dir)
      DIR_DOWN_RIGHT: rn = {1'b0, r} + 4'd1;
      DIR_DOWN_LEFT: begin
        rn = {1'b0, r} + 4'd1;
        kn = {1'b0, k} + 4'd1;
      end
      DIR_UP_RIGHT: begin
        rn = {1'b0, r} - 4'd1;
        kn = {1'b0, k} - 4'd1;
      end
      DIR_UP_LEFT: rn = {1'b0, r} - 4'd1;
      default: ;
    endcase
    // Row 8 does not fit the 3-bit outputs, so 'off' is the authority there.
    off    = !dir_legal(dir) || (rn == 4'd0) || (rn > 4'd7) || (kn == 4'd0) || (kn > rn);
    r_next = rn[2:0];
    k_next = kn[2:0];
    onehot = off ? '0 : rk_onehot(rn, kn);
  end

endmodule

// File: rtl/qbert_move_ctrl.sv
// Q*bert jump sequencer: command intake, layer handshake, visited mask, lives.
// Build option: QBERT_CMD_BUF_EN adds a 1-entry command buffer accepted while busy.
//
// state  | meaning
// IDLE   | ready for a direction command
// ARM    | jump issued, waiting for layer to drop done_move
// MOVE   | layer jumping, waiting for done_move
// LAND   | commit position and visited mask
// KO_A   | bad jump, waiting for layer START
// KO_B   | waiting for layer IDLE, then lose a life
// OVER   | out of lives until game_start
module qbert_move_ctrl
  import qbert_pkg::*;
#(
  parameter int N_LIVES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              game_start,
  input  logic              pause,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_dir,
  output logic              cmd_ready,
  input  logic              done_move,
  input  logic [2:0]        state_qb,
  output logic [N_CUBE-1:0] position_qb,
  output logic [N_CUBE-1:0] e_next_qb,
  output logic [2:0]        e_jump_qb,
  output logic              e_bad_jump,
  output logic [N_CUBE-1:0] visited,
  output logic [4:0]        visited_cnt,
  output logic [2:0]        lives,
  output logic              level_done,
  output logic              game_over,
  output logic              busy
);

  ctrl_state_e       state;
  logic [2:0]        pos_r, pos_k;
  logic [2:0]        nxt_r, nxt_k;
  logic [2:0]        nav_dir, nav_r, nav_k;
  logic              nav_off;
  logic [N_CUBE-1:0] nav_oh;
  logic              issue_req;
  logic              land_new;

`ifdef QBERT_CMD_BUF_EN
  logic       buf_valid;
  logic [2:0] buf_dir;
  assign cmd_ready = !buf_valid && (state != S_OVER) && !pause;
  assign nav_dir   = buf_valid ? buf_dir : cmd_dir;
  assign issue_req = buf_valid || cmd_valid;
`else
  assign cmd_ready = (state == S_IDLE) && !pause;
  assign nav_dir   = cmd_dir;
  assign issue_req = cmd_valid;
`endif

  qbert_cube_nav u_nav (
    .r      (pos_r),
    .k      (pos_k),
    .dir    (nav_dir),
    .r_next (nav_r),
    .k_next (nav_k),
    .off    (nav_off),
    .onehot (nav_oh)
  );

  assign position_qb = rk_onehot({1'b0, pos_r}, {1'b0, pos_k});
  assign busy        = !((state == S_IDLE) || (state == S_OVER));
  assign land_new    = (visited & e_next_qb) == '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      pos_r       <= 3'd1;
      pos_k       <= 3'd1;
      nxt_r       <= 3'd1;
      nxt_k       <= 3'd1;
      e_next_qb   <= TOP;
      e_jump_qb   <= 3'd0;
      e_bad_jump  <= 1'b0;
      visited     <= TOP;
      visited_cnt <= 5'd1;
      lives       <= 3'(N_LIVES);
      level_done  <= 1'b0;
      game_over   <= 1'b0;
`ifdef QBERT_CMD_BUF_EN
      buf_valid   <= 1'b0;
      buf_dir     <= 3'd0;
`endif
    end else if (game_start) begin
      state       <= S_IDLE;
      pos_r       <= 3'd1;
      pos_k       <= 3'd1;
      nxt_r       <= 3'd1;
      nxt_k       <= 3'd1;
      e_next_qb   <= TOP;
      e_jump_qb   <= 3'd0;
      e_bad_jump  <= 1'b0;
      visited     <= TOP;
      visited_cnt <= 5'd1;
      lives       <= 3'(N_LIVES);
      level_done  <= 1'b0;
      game_over   <= 1'b0;
`ifdef QBERT_CMD_BUF_EN
      buf_valid   <= 1'b0;
      buf_dir     <= 3'd0;
`endif
    end else begin
      level_done <= 1'b0;
      if (!pause) begin
`ifdef QBERT_CMD_BUF_EN
        if (cmd_valid && cmd_ready && (state != S_IDLE)) begin
          buf_valid <= 1'b1;
          buf_dir   <= cmd_dir;
        end
`endif
        case (state)
          S_IDLE: begin
`ifdef QBERT_CMD_BUF_EN
            if (buf_valid) buf_valid <= 1'b0;
`endif
            // Illegal directions are consumed without effect.
            if (issue_req && dir_legal(nav_dir)) begin
              e_jump_qb  <= nav_dir;
              e_next_qb  <= nav_oh;
              e_bad_jump <= nav_off;
              nxt_r      <= nav_r;
              nxt_k      <= nav_k;
              state      <= S_ARM;
            end
          end
          S_ARM: if (!done_move) state <= S_MOVE;
          S_MOVE: begin
            if (done_move) begin
              if (e_bad_jump) begin
                pos_r     <= 3'd1;
                pos_k     <= 3'd1;
                nxt_r     <= 3'd1;
                nxt_k     <= 3'd1;
                e_next_qb <= TOP;
                e_jump_qb <= 3'd0;
                state     <= S_KO_A;
`ifdef QBERT_CMD_BUF_EN
                buf_valid <= 1'b0;
`endif
              end else begin
                state <= S_LAND;
              end
            end
          end
          S_LAND: begin
            pos_r     <= nxt_r;
            pos_k     <= nxt_k;
            e_jump_qb <= 3'd0;
            visited   <= visited | e_next_qb;
            if (land_new && (visited_cnt < 5'd28)) begin
              visited_cnt <= visited_cnt + 5'd1;
              if (visited_cnt == 5'd27) level_done <= 1'b1;
            end
            state <= S_IDLE;
          end
          S_KO_A: if (state_qb == LQ_START) state <= S_KO_B;
          S_KO_B: begin
            if (state_qb == LQ_IDLE) begin
              lives      <= lives - 3'd1;
              e_bad_jump <= 1'b0;
              game_over  <= (lives == 3'd1);
              state      <= (lives == 3'd1) ? S_OVER : S_IDLE;
            end
          end
          S_OVER: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/qbert_move_ctrl.md
# qbert_move_ctrl

Jump sequencer for the Q*bert sprite layer. It accepts direction commands from the NIOS/joystick side and computes the destination cube on the 28-cube pyramid. It drives the layer's jump, next-position and bad-jump inputs, then tracks the layer's move handshake until landing or KO recovery. It also owns the visited-cube mask, the lives counter and the level/game-over flags.

## Interface
- `N_LIVES`, 3: lives at game start, range 1..7.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-low.
- `game_start` in 1: synchronous re-init pulse.
- `pause` in 1: freezes the FSM and command acceptance while high.
- `cmd_valid` in 1, `cmd_dir` in 3, `cmd_ready` out 1: command handshake. Directions: 001 DOWN_RIGHT, 010 DOWN_LEFT, 011 UP_RIGHT, 100 UP_LEFT.
- `done_move` in 1: landed flag from the sprite layer.
- `state_qb` in 3: layer state (000 START, 001 JUMP, 010 IDLE, 011 SAUCER, 100 KO).
- `position_qb` out 28: one-hot current cube; bit0 is TOP.
- `e_next_qb` out 28: one-hot destination; 0 when the destination is off the pyramid.
- `e_jump_qb` out 3: active direction; 0 when idle.
- `e_bad_jump` out 1: high when the current jump leaves the pyramid.
- `visited` out 28, `visited_cnt` out 5.
- `lives` out 3, `level_done` out 1 (pulse), `game_over` out 1, `busy` out 1.

## Operation
- Cube n (bit n-1) sits at row r (1..7) and slot k (1..r), with n = r(r-1)/2 + k. Right edge is k=1; left edge is k=r.
- Direction moves:
  - DOWN_RIGHT: (r+1,k)
  - DOWN_LEFT: (r+1,k+1)
  - UP_RIGHT: (r-1,k-1)
  - UP_LEFT: (r-1,k)
- A move is off the pyramid if r'=0, r'=8, k'=0 or k'>r'.
- Row and slot are held internally as 3-bit registers; the one-hot outputs are decoded from them.
- FSM states:
  - IDLE: `cmd_ready`=1.
    - Legal direction accepted → register `e_jump_qb`, `e_next_qb`, `e_bad_jump`; go to ARM.
    - Direction 000 or 101..111: accepted, then discarded; stay in IDLE.
  - ARM: wait for `done_move`=0 (layer has entered JUMP).
  - MOVE: wait for `done_move`=1.
    - Good jump → LAND.
    - Bad jump → set position to TOP, `e_next_qb`=TOP, `e_jump_qb`=0 (`e_bad_jump` stays 1); go to KO_A.
  - LAND (1 cycle):
    - `position_qb`←`e_next_qb`, `e_jump_qb`←0.
    - Set the visited bit. If it was new, `visited_cnt`+1.
    - If the count reaches 28, pulse `level_done`.
    - Go to IDLE.
  - KO_A: wait for `state_qb`=START.
  - KO_B: wait for `state_qb`=IDLE, then `lives`−1 and `e_bad_jump`←0. Go to OVER if `lives` is now 0, else IDLE.
  - OVER: `game_over`=1, `cmd_ready`=0. Only `game_start` or `reset` leaves this state.
- `busy` = (state ≠ IDLE, OVER).
- `pause` high: all state registers hold and `cmd_ready`=0. Layer inputs stay driven unchanged.
- `game_start` has priority over everything, including a simultaneous `cmd_valid` (that command is not accepted). It restores all reset values and returns to IDLE from any state.
- A revisit never increments `visited_cnt`; `visited_cnt` saturates at 28.

## Timing
- Reset values:
  - `position_qb`=`e_next_qb`=28'h1, `visited`=28'h1, `visited_cnt`=1
  - `e_jump_qb`=0, `e_bad_jump`=0
  - `lives`=`N_LIVES`
  - `level_done`=0, `game_over`=0, `busy`=0
  - `cmd_ready`=1 (IDLE)
- Handshake: a command is accepted on the edge where `cmd_valid`&&`cmd_ready`. Layer outputs are valid 1 cycle later and held stable until LAND or MOVE exit.
- Landing: `done_move` seen high at edge N → outputs update at edge N+1.
- Invariant: `position_qb`==`e_next_qb` whenever `e_jump_qb`=0. This prevents the layer from re-triggering a jump.

## Configuration
- `QBERT_CMD_BUF_EN` defined: adds a 1-entry command buffer.
  - `cmd_ready` = !buf_valid && state≠OVER && !pause.
  - Commands accepted while busy are stored in the buffer.
  - In IDLE, a buffered command is issued before a new input command, 1 cycle after LAND.
  - The buffer is flushed on a bad-jump landing, on `game_start` and on reset.
- Undefined: `cmd_ready` is high only in IDLE with `pause`=0, and no buffer exists.

## Structure
- Package `qbert_pkg` holds:
  - direction enum
  - layer state codes
  - `N_CUBE`=28 and TOP=28'h1
  - controller FSM enum
- Sub-module `qbert_cube_nav` is combinational. Inputs: (r, k, dir). Outputs: (r', k', off, onehot[27:0]). It is reused by future enemy controllers.

## Test plan
- Reset, then release: all outputs at the reset values above, `cmd_ready`=1.
- Cmd 001 from TOP: next cycle `e_jump_qb`=001, `e_next_qb`=28'h2, `e_bad_jump`=0. Then `done_move` 1→0→1 gives `position_qb`=28'h2, `visited`=28'h3, `visited_cnt`=2, `e_jump_qb`=0.
- Cmd 100 from TOP: `e_next_qb`=0, `e_bad_jump`=1. After landing, with `state_qb` KO→START→IDLE: `lives` 3→2, `position_qb`=28'h1, `e_bad_jump`=0.
- Three consecutive bad jumps: `game_over`=1, `cmd_ready`=0, further `cmd_valid` ignored. Then `game_start`: `lives`=3, state IDLE.
- Path covering all 28 cubes: exactly one `level_done` pulse at `visited_cnt`=28. A revisit leaves the count at 28.
- With `QBERT_CMD_BUF_EN`:
  - A second command during MOVE is accepted; a third is refused (`cmd_ready`=0).
  - The buffered command issues 1 cycle after LAND.
  - `game_start` mid-move returns to IDLE and clears the buffer.
